// File: rtl/rate_encoder_if.sv
// Frame-in / spike-out bus of the rate encoder: pixel handshake, abort, and the
// network-facing spike/sample strobe pair.
interface rate_encoder_if #(
  parameter int unsigned NInputs       = 4,
  parameter int unsigned PixelBitwidth = 8
);
  logic                              pixel_valid;
  logic                              pixel_ready;
  logic [NInputs*PixelBitwidth-1:0]  pixels;
  logic                              clear;
  logic                              sample;
  logic                              sample_ready;
  logic [NInputs-1:0]                spikes;
  logic                              frame_done;

  // Driver side: pixel source plus the consuming network.
  modport master (
    output pixel_valid, pixels, clear, sample,
    input  pixel_ready, sample_ready, spikes, frame_done
  );

  modport slave (
    input  pixel_valid, pixels, clear, sample,
    output pixel_ready, sample_ready, spikes, frame_done
  );
endinterface

// File: rtl/rate_encoder.sv
// Deterministic rate coder: each channel adds its pixel into a W-bit accumulator
// per timestep and spikes on carry-out, so spike density tracks pixel/2^W.
module rate_encoder #(
  parameter int unsigned NInputs           = 4,
  parameter int unsigned PixelBitwidth     = 8,
  parameter int unsigned NCycles           = 10,
  parameter int unsigned CyclesCntBitwidth = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  rate_encoder_if.slave  enc_io
);

  localparam int unsigned W = PixelBitwidth;
  localparam logic [CyclesCntBitwidth-1:0] LastStep = CyclesCntBitwidth'(NCycles);

  typedef enum logic [0:0] {StIdle, StEncode} state_e;

  state_e state_q, state_d;

  logic [NInputs-1:0][W-1:0]      pix_q, pix_d;
  logic [NInputs-1:0][W-1:0]      acc_q, acc_d;
  logic [CyclesCntBitwidth-1:0]   step_cnt_q, step_cnt_d;
  logic                           pixel_ready_q, pixel_ready_d;
  logic                           sample_ready_q, sample_ready_d;
  logic                           frame_done_q, frame_done_d;
  logic [NInputs-1:0]             spikes_q, spikes_d;

  logic                           accept, advance, finish;
  logic [NInputs-1:0][W-1:0]      src_pix;
  logic [NInputs-1:0][W:0]        step_sum;
  logic [NInputs-1:0]             step_spk;
  logic [NInputs-1:0][W-1:0]      step_acc;

  assign accept  = pixel_ready_q && enc_io.pixel_valid;
  assign advance = (state_q == StEncode) && enc_io.sample && (step_cnt_q != LastStep);
  assign finish  = (state_q == StEncode) && enc_io.sample && (step_cnt_q == LastStep);

  // One step of the adder array; on acceptance step 1 runs on the incoming
  // pixels with a zero accumulator so the first vector is ready next cycle.
  always_comb begin
    src_pix  = pix_q;
    step_sum = '0;
    step_spk = '0;
    step_acc = '0;
    for (int i = 0; i < NInputs; i++) begin
      if (accept) begin
        src_pix[i]  = enc_io.pixels[i*W +: W];
        step_sum[i] = {1'b0, src_pix[i]};
      end else begin
        step_sum[i] = {1'b0, acc_q[i]} + {1'b0, src_pix[i]};
      end
      step_spk[i] = step_sum[i][W];
      step_acc[i] = step_sum[i][W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (accept) state_d = StEncode;
      StEncode: if (finish) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (enc_io.clear) state_d = StIdle;
  end

  // clear outranks everything, so it is tested first.
  always_comb begin
    pix_d          = pix_q;
    acc_d          = acc_q;
    step_cnt_d     = step_cnt_q;
    pixel_ready_d  = pixel_ready_q;
    sample_ready_d = sample_ready_q;
    spikes_d       = spikes_q;
    frame_done_d   = 1'b0;
    if (enc_io.clear) begin
      acc_d          = '0;
      step_cnt_d     = '0;
      pixel_ready_d  = 1'b1;
      sample_ready_d = 1'b0;
      spikes_d       = '0;
    end else if (accept) begin
      pix_d          = src_pix;
      acc_d          = step_acc;
      spikes_d       = step_spk;
      step_cnt_d     = CyclesCntBitwidth'(1);
      pixel_ready_d  = 1'b0;
      sample_ready_d = 1'b1;
    end else if (advance) begin
      acc_d          = step_acc;
      spikes_d       = step_spk;
      step_cnt_d     = step_cnt_q + CyclesCntBitwidth'(1);
    end else if (finish) begin
      acc_d          = '0;
      step_cnt_d     = '0;
      pixel_ready_d  = 1'b1;
      sample_ready_d = 1'b0;
      spikes_d       = '0;
      frame_done_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_q          <= '0;
      acc_q          <= '0;
      step_cnt_q     <= '0;
      pixel_ready_q  <= 1'b1;
      sample_ready_q <= 1'b0;
      spikes_q       <= '0;
      frame_done_q   <= 1'b0;
    end else begin
      pix_q          <= pix_d;
      acc_q          <= acc_d;
      step_cnt_q     <= step_cnt_d;
      pixel_ready_q  <= pixel_ready_d;
      sample_ready_q <= sample_ready_d;
      spikes_q       <= spikes_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign enc_io.pixel_ready  = pixel_ready_q;
  assign enc_io.sample_ready = sample_ready_q;
  assign enc_io.spikes       = spikes_q;
  assign enc_io.frame_done   = frame_done_q;

endmodule

// File: doc/rate_encoder.md
Name: rate_encoder

Overview:
Upstream stage of the spiking network: converts a frame of n_inputs pixel intensities into deterministic rate-coded spike trains over n_cycles timesteps. It accepts a pixel frame via a valid/ready handshake. It presents one spike vector per timestep to the network's in_spikes/sample_ready/sample interface and advances on each network sample strobe. After n_cycles timesteps it returns to idle and accepts the next frame.

Parameters:
n_inputs, 4, number of input channels (width of spikes)
pixel_bitwidth, 8, bits per pixel intensity; also accumulator width W
n_cycles, 10, timesteps per frame; must be >= 1 and <= 2^cycles_cnt_bitwidth-1
cycles_cnt_bitwidth, 5, width of the timestep counter

Ports:
clk  input  1  clock
rst_n  input  1  reset; asynchronous assert, active-low
pixel_valid  input  1  pixel frame present on pixels
pixel_ready  output  1  encoder idle; frame accepted when pixel_valid && pixel_ready
pixels  input  n_inputs*pixel_bitwidth  channel i at pixels[i*W +: W], unsigned
clear  input  1  synchronous abort of current frame
sample  input  1  network strobe: current spike vector consumed this cycle
sample_ready  output  1  spikes holds a valid timestep vector
spikes  output  n_inputs  spike vector, feeds network in_spikes; bit i = channel i
frame_done  output  1  one-cycle pulse after last timestep consumed

Behaviour:
- Reset (rst_n=0, async): state IDLE, pixel_ready=1, sample_ready=0, spikes=0, frame_done=0, all accumulators, pixel registers and step counter 0.
- All outputs registered.
- State IDLE (pixel_ready=1, sample_ready=0, spikes=0):
  - On pixel_valid && pixel_ready: latch pix_i<=pixels channel i; compute step 1 from acc=0.
  - Next cycle: state ENCODE, pixel_ready=0, sample_ready=1, step_cnt=1, spikes=step-1 vector.
- Step arithmetic per channel: sum = acc_i + pix_i, computed W+1 bits wide.
  - spike_i = sum[W]; acc_i <= sum[W-1:0].
  - Cumulative spike count after k steps = floor(k*pix_i/2^W).
  - pix=0 never spikes; pix=2^W-1 spikes every step except step 1.
- State ENCODE: spikes and sample_ready held stable until a sample cycle.
  - On sample=1 with step_cnt<n_cycles: next cycle spikes=next step vector, step_cnt+1, sample_ready stays 1.
    - Back-to-back sample every cycle is legal, giving one step per cycle.
  - On sample=1 with step_cnt==n_cycles: next cycle state IDLE, sample_ready=0, spikes=0, pixel_ready=1, frame_done=1 for exactly one cycle.
- sample while sample_ready=0: ignored.
- pixel_valid while pixel_ready=0: ignored, not queued.
  - A frame presented in the same cycle as the final sample is not accepted; earliest acceptance is the frame_done cycle.
- clear=1, any state: next cycle IDLE, pixel_ready=1, sample_ready=0, spikes=0, accumulators 0, frame_done=0.
  - clear has priority over sample and pixel_valid in the same cycle.
- n_cycles=1: one vector (step 1) presented; first sample ends the frame.
- Async reset mid-frame: immediate return to reset values; frame discarded.

Test Plan:
1. Reset with rst_n=0 for 3 cycles -> pixel_ready=1, sample_ready=0, spikes=0, frame_done=0; after release these values persist with pixel_valid=0.
2. Load ch3=255, ch2=0, ch1=128, ch0=64, sample=1 every cycle, n_cycles=10 -> 10 vectors:
   - ch3 spikes steps 2-10 (9 total); ch1 spikes steps 2,4,6,8,10; ch0 spikes steps 4,8; ch2 never spikes.
   - frame_done pulses one cycle after the 10th sample.
3. Same frame, sample pulsed once every 7 cycles -> identical 10-vector sequence; spikes constant between pulses; sample_ready=1 throughout.
4. pixel_valid held 1 with new pixels during the frame -> pixel_ready=0 and frame unchanged; new frame latched in the frame_done cycle; sample_ready=1 the following cycle.
5. clear asserted after the 4th sample, together with sample=1 -> next cycle IDLE, spikes=0, no frame_done; reload of the same frame restarts at step 1 with an identical sequence.
6. rst_n dropped mid-cycle at step 6 -> outputs immediately at reset values without waiting for a clk edge; the next frame encodes correctly from step 1.
